// File: rtl/gabor_conv_pipe_if.sv
// Stream, coefficient and result signals of the Gabor convolution pipe.
// master drives windows/coefficients, slave is the filter itself.
interface gabor_conv_pipe_if #(
  parameter int PIX_W   = 9,
  parameter int COEFF_W = 17,
  parameter int OUT_W   = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [1:0]                in_mode;
  logic [25*PIX_W-1:0]       in_pix;
  logic                      coeff_we;
  logic [2:0]                coeff_addr;
  logic [COEFF_W-1:0]        coeff_wdata;
  logic                      coeff_ready;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [OUT_W-1:0]   out_data;
  logic                      out_sat;

  modport master (
    output in_valid, in_mode, in_pix,
    output coeff_we, coeff_addr, coeff_wdata,
    output out_ready,
    input  in_ready, coeff_ready,
    input  out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_mode, in_pix,
    input  coeff_we, coeff_addr, coeff_wdata,
    input  out_ready,
    output in_ready, coeff_ready,
    output out_valid, out_data, out_sat
  );
endinterface

// File: rtl/gabor_conv_pipe.sv
// Streaming 5x5 oriented Gabor filter: window capture, group sums,
// products, accumulate, round/saturate. Valid/ready on both sides.
module gabor_conv_pipe #(
  parameter int PIX_W      = 9,
  parameter int COEFF_W    = 17,
  parameter int COEFF_FRAC = 15,
  parameter int OUT_W      = 16,
  parameter int OUT_FRAC   = 0,
  parameter int ROUND      = 1
) (
  input logic clk,
  input logic rst,
  gabor_conv_pipe_if.slave bus
);

  localparam int GW  = PIX_W + 4;
  localparam int PW  = GW + COEFF_W;
  localparam int AW  = PW + 3;
  localparam int SH  = COEFF_FRAC - OUT_FRAC;
  localparam int RSH = (SH > 0) ? SH - 1 : 0;

  // group of pixel k, 3 bits per entry, k=24 first
  localparam logic [74:0] G135 = {
    3'd0, 3'd1, 3'd0, 3'd1, 3'd2,
    3'd3, 3'd0, 3'd1, 3'd0, 3'd1,
    3'd2, 3'd3, 3'd4, 3'd3, 3'd2,
    3'd1, 3'd0, 3'd1, 3'd0, 3'd3,
    3'd2, 3'd1, 3'd0, 3'd1, 3'd0
  };
  localparam logic [74:0] G0 = {
    3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
    3'd1, 3'd1, 3'd1, 3'd1, 3'd1,
    3'd2, 3'd3, 3'd4, 3'd3, 3'd2,
    3'd1, 3'd1, 3'd1, 3'd1, 3'd1,
    3'd0, 3'd0, 3'd0, 3'd0, 3'd0
  };

  localparam logic signed [AW:0] ONE =
    {{AW{1'b0}}, 1'b1};
  localparam logic signed [AW:0] RND =
    (ROUND != 0 && SH > 0) ? (ONE <<< RSH) : '0;
  localparam logic signed [AW:0] MAXV =
    {{(AW+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [AW:0] MINV =
    {{(AW+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic logic [2:0] grp(
    input logic [1:0] m,
    input int         k
  );
    int r;
    int c;
    logic [2:0] g;
    r = k / 5;
    c = k % 5;
    g = '0;
    unique case (m)
      2'd0: g = G0[3*k +: 3];
      2'd1: g = G135[3*(r*5+4-c) +: 3];
      2'd2: g = G0[3*(c*5+r) +: 3];
      2'd3: g = G135[3*k +: 3];
    endcase
    return g;
  endfunction

  logic adv;
  logic take;

  logic v0_q, v1_q, v2_q, v3_q, ov_q;
  logic [1:0] m0_q;
  logic signed [PIX_W-1:0] px_q [25];
  logic signed [GW-1:0] gs_d [5];
  logic signed [GW-1:0] gs_q [5];
  logic signed [PW-1:0] p_d [5];
  logic signed [PW-1:0] p_q [5];
  logic signed [AW-1:0] acc_d, acc_q;
  logic signed [COEFF_W-1:0] c_q [5];
  logic signed [AW:0] rnd_w, shr_w;
  logic signed [OUT_W-1:0] od_d, od_q;
  logic sat_d, sat_q;

  assign adv  = !ov_q || bus.out_ready;
  assign take = bus.in_valid && bus.in_ready;

  assign bus.in_ready    = adv && !bus.coeff_we;
  assign bus.coeff_ready =
    !(v0_q || v1_q || v2_q || v3_q || ov_q);
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign bus.out_sat   = sat_q;

  always_comb begin
    for (int g = 0; g < 5; g++) begin
      gs_d[g] = '0;
      for (int k = 0; k < 25; k++) begin
        if (grp(m0_q, k) == 3'(g))
          gs_d[g] = gs_d[g] + GW'(px_q[k]);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 5; i++)
      p_d[i] = PW'(gs_q[i]) * PW'(c_q[i]);
  end

  always_comb begin
    acc_d = '0;
    for (int i = 0; i < 5; i++)
      acc_d = acc_d + AW'(p_q[i]);
  end

  always_comb begin
    rnd_w = {acc_q[AW-1], acc_q} + RND;
    shr_w = rnd_w >>> SH;
    od_d  = shr_w[OUT_W-1:0];
    sat_d = 1'b0;
    if (shr_w > MAXV) begin
      od_d  = MAXV[OUT_W-1:0];
      sat_d = 1'b1;
    end else if (shr_w < MINV) begin
      od_d  = MINV[OUT_W-1:0];
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q  <= 1'b0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      ov_q  <= 1'b0;
      od_q  <= '0;
      sat_q <= 1'b0;
      for (int i = 0; i < 5; i++)
        c_q[i] <= '0;
    end else begin
      if (bus.coeff_we && bus.coeff_ready) begin
        for (int i = 0; i < 5; i++)
          if (bus.coeff_addr == 3'(i))
            c_q[i] <= bus.coeff_wdata;
      end
      if (adv) begin
        v0_q <= take;
        v1_q <= v0_q;
        v2_q <= v1_q;
        v3_q <= v2_q;
        ov_q <= v3_q;
        if (take) begin
          m0_q <= bus.in_mode;
          for (int k = 0; k < 25; k++)
            px_q[k] <= bus.in_pix[k*PIX_W +: PIX_W];
        end
        if (v0_q) gs_q  <= gs_d;
        if (v1_q) p_q   <= p_d;
        if (v2_q) acc_q <= acc_d;
        if (v3_q) begin
          od_q  <= od_d;
          sat_q <= sat_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_gabor_conv_pipe.sv
// Random and directed stimulus against a set-based reference model,
// one pipe with 16-bit rounded output, one with 12-bit truncated output.
module tb_gabor_conv_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid;
  logic [1:0]   in_mode;
  logic [224:0] in_pix;
  logic         coeff_we;
  logic [2:0]   coeff_addr;
  logic [16:0]  coeff_wdata;
  logic         out_ready;

  gabor_conv_pipe_if #(.OUT_W(16)) ifa ();
  gabor_conv_pipe_if #(.OUT_W(12)) ifb ();

  assign ifa.in_valid    = in_valid;
  assign ifa.in_mode     = in_mode;
  assign ifa.in_pix      = in_pix;
  assign ifa.coeff_we    = coeff_we;
  assign ifa.coeff_addr  = coeff_addr;
  assign ifa.coeff_wdata = coeff_wdata;
  assign ifa.out_ready   = out_ready;
  assign ifb.in_valid    = in_valid;
  assign ifb.in_mode     = in_mode;
  assign ifb.in_pix      = in_pix;
  assign ifb.coeff_we    = coeff_we;
  assign ifb.coeff_addr  = coeff_addr;
  assign ifb.coeff_wdata = coeff_wdata;
  assign ifb.out_ready   = out_ready;

  gabor_conv_pipe #(.OUT_W(16), .ROUND(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );
  gabor_conv_pipe #(.OUT_W(12), .ROUND(0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );

  typedef struct {
    longint da;
    bit     sa;
    longint db;
    bit     sb;
    int     acyc;
    bit     lat;
  } exp_t;

  int n_chk = 0;
  int n_fail = 0;
  int n_out = 0;
  int cyc = 0;
  longint cm [5];
  exp_t q [$];
  exp_t me;

  int S135 [5][10] = '{
    '{0, 2, 6, 8, 16, 18, 22, 24, -1, -1},
    '{1, 3, 7, 9, 15, 17, 21, 23, -1, -1},
    '{4, 10, 14, 20, -1, -1, -1, -1, -1, -1},
    '{5, 11, 13, 19, -1, -1, -1, -1, -1, -1},
    '{12, -1, -1, -1, -1, -1, -1, -1, -1, -1}
  };
  int S0 [5][10] = '{
    '{0, 1, 2, 3, 4, 20, 21, 22, 23, 24},
    '{5, 6, 7, 8, 9, 15, 16, 17, 18, 19},
    '{10, 14, -1, -1, -1, -1, -1, -1, -1, -1},
    '{11, 13, -1, -1, -1, -1, -1, -1, -1, -1},
    '{12, -1, -1, -1, -1, -1, -1, -1, -1, -1}
  };

  task automatic check(
    input string  tag,
    input longint got,
    input longint exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  // mirror for 45 deg, transpose for 90 deg
  function automatic int xf(input int mode, input int s);
    case (mode)
      1: return (s / 5) * 5 + 4 - (s % 5);
      2: return (s % 5) * 5 + (s / 5);
      default: return s;
    endcase
  endfunction

  function automatic void fin(
    input  longint acc,
    input  int     rnd,
    input  int     ow,
    output longint d,
    output bit     s
  );
    longint a, mx, mn;
    a  = acc;
    if (rnd != 0) a = a + 16384;
    a  = a >>> 15;
    mx = (longint'(1) <<< (ow - 1)) - 1;
    mn = -(longint'(1) <<< (ow - 1));
    s  = 1'b0;
    d  = a;
    if (a > mx) begin d = mx; s = 1'b1; end
    if (a < mn) begin d = mn; s = 1'b1; end
  endfunction

  function automatic exp_t model(
    input int mode,
    input int px [25]
  );
    exp_t e;
    longint acc, gs;
    int s;
    acc = 0;
    for (int g = 0; g < 5; g++) begin
      gs = 0;
      for (int j = 0; j < 10; j++) begin
        s = (mode == 0 || mode == 2) ? S0[g][j] : S135[g][j];
        if (s >= 0) gs = gs + px[xf(mode, s)];
      end
      acc = acc + gs * cm[g];
    end
    fin(acc, 1, 16, e.da, e.sa);
    fin(acc, 0, 12, e.db, e.sb);
    e.acyc = 0;
    e.lat  = 1'b0;
    return e;
  endfunction

  task automatic beat(
    input int mode,
    input int px [25],
    input bit lat
  );
    exp_t e;
    int n;
    in_valid = 1'b1;
    in_mode  = mode[1:0];
    for (int k = 0; k < 25; k++)
      in_pix[k*9 +: 9] = px[k][8:0];
    n = 0;
    @(negedge clk);
    while (!ifa.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept", ifa.in_ready, 1);
    e = model(mode, px);
    e.acyc = cyc;
    e.lat  = lat;
    q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic cw(
    input int addr,
    input int val,
    input bit ok
  );
    logic [16:0] v;
    v = val[16:0];
    coeff_we    = 1'b1;
    coeff_addr  = addr[2:0];
    coeff_wdata = v;
    @(negedge clk);
    check("coeff_ready", ifa.coeff_ready, ok);
    check("in_ready_we", ifa.in_ready, 0);
    if (ok && addr < 5) cm[addr] = longint'($signed(v));
    @(posedge clk);
    #1 coeff_we = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", q.size(), 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic void fill(output int px [25], input int v);
    for (int k = 0; k < 25; k++) px[k] = v;
  endfunction

  function automatic void rnd_pix(output int px [25]);
    for (int k = 0; k < 25; k++)
      px[k] = int'($urandom_range(0, 511)) - 256;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (ifa.out_valid && !out_ready)
        check("in_ready_stall", ifa.in_ready, 0);
      if (ifa.out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("extra_out", 1, 0);
        end else begin
          me = q.pop_front();
          check("data16", ifa.out_data, me.da);
          check("sat16", ifa.out_sat, me.sa);
          check("valid12", ifb.out_valid, 1);
          check("data12", ifb.out_data, me.db);
          check("sat12", ifb.out_sat, me.sb);
          if (me.lat) check("latency", cyc - me.acyc, 5);
          n_out++;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int px [25];
    int n0;
    bit done;
    rst = 1'b1;
    in_valid = 1'b0;
    in_mode = '0;
    in_pix = '0;
    coeff_we = 1'b0;
    coeff_addr = '0;
    coeff_wdata = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) cm[i] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", ifa.out_valid, 0);
    check("rst_data", ifa.out_data, 0);
    check("rst_sat", ifa.out_sat, 0);
    check("rst_cready", ifa.coeff_ready, 1);
    check("rst_iready", ifa.in_ready, 1);
    @(posedge clk);
    #1;

    // single beat, 135 deg, c0 = 1.0
    cw(0, 'h08000, 1);
    fill(px, 1);
    beat(3, px, 1);
    drain();

    // four orientations back to back
    for (int i = 1; i < 5; i++) cw(i, 'h08000, 1);
    for (int m = 0; m < 4; m++) beat(m, px, 1);
    drain();

    // rounding on the centre pixel, c4 = 0.5
    for (int i = 0; i < 4; i++) cw(i, 0, 1);
    cw(4, 'h04000, 1);
    fill(px, 0);
    px[12] = 1;
    beat(0, px, 0);
    px[12] = -1;
    beat(0, px, 0);
    drain();

    // saturation in both directions
    for (int i = 0; i < 5; i++) cw(i, 'h08000, 1);
    fill(px, 255);
    beat(0, px, 0);
    fill(px, -256);
    beat(0, px, 0);
    drain();

    // backpressure mid-stream
    n0 = n_out;
    fork
      begin
        for (int b = 0; b < 8; b++) begin
          rnd_pix(px);
          beat(b % 4, px, 0);
        end
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", n_out - n0, 8);

    // write during flight is dropped, old c0 still used
    rnd_pix(px);
    beat(1, px, 0);
    cw(0, 'h10000, 0);
    drain();
    fill(px, 3);
    beat(2, px, 0);
    drain();

    // out-of-range address leaves the bank unchanged
    cw(5, 'h1ffff, 1);
    cw(7, 'h12345, 1);
    beat(3, px, 0);
    drain();

    // random coefficients, beats and stalls
    for (int i = 0; i < 5; i++)
      cw(i, int'($urandom_range(0, 'h1ffff)), 1);
    n0 = n_out;
    done = 1'b0;
    fork
      begin
        for (int b = 0; b < 40; b++) begin
          int gap;
          gap = int'($urandom_range(0, 2));
          if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
          end
          rnd_pix(px);
          beat(int'($urandom_range(0, 3)), px, 0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("rand_count", n_out - n0, 40);

    // reset with three beats in flight
    for (int b = 0; b < 3; b++) begin
      rnd_pix(px);
      beat(b, px, 0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    for (int i = 0; i < 5; i++) cm[i] = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_valid", ifa.out_valid, 0);
    end
    check("post_rst_data", ifa.out_data, 0);
    check("post_rst_sat", ifa.out_sat, 0);
    check("post_rst_cready", ifa.coeff_ready, 1);
    @(posedge clk);
    #1;
    fill(px, 100);
    beat(0, px, 0);
    drain();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
